// File: rtl/round_ctrl.sv
// Game-flow controller for Crossy Robbers: menu, countdown, timed play, pause,
// intermission and game end. Optional pause feature: define ROUND_CTRL_PAUSE_EN.
module round_ctrl #(
  parameter int ROUND_FRAMES     = 7142,
  parameter int NUM_ROUNDS       = 3,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int LED_W            = 10,
  parameter int TIMER_W          = 16
) (
  input  logic                            FrameClk,
  input  logic                            Reset,
  input  logic                            Continue,
  input  logic                            Pause,
  output logic                            SpawnEnable,
  output logic [$clog2(NUM_ROUNDS+1)-1:0] RoundNum,
  output logic [2:0]                      State,
  output logic                            RoundDone,
  output logic [LED_W-1:0]                LED
);

  localparam int RW = $clog2(NUM_ROUNDS + 1);
  localparam int PW = TIMER_W + $clog2(LED_W) + 1;

  localparam logic [TIMER_W-1:0] CD_LAST    = TIMER_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [TIMER_W-1:0] PLAY_LAST  = TIMER_W'(ROUND_FRAMES - 1);
  localparam logic [RW-1:0]      LAST_ROUND = RW'(NUM_ROUNDS);
  localparam logic [LED_W-1:0]   LED_ONES   = '1;

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSED    = 3'd3,
    S_INTER     = 3'd4,
    S_END       = 3'd5
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [RW-1:0]        round;
  logic                 done_q;
  logic                 cont_q;
  logic                 cont_p;
  logic                 pause_p;

  // Edge detectors preset to 1 so a button held through reset gives no edge.
  always_ff @(posedge FrameClk) begin
    if (Reset) cont_q <= 1'b1;
    else       cont_q <= Continue;
  end
  assign cont_p = Continue & ~cont_q;

`ifdef ROUND_CTRL_PAUSE_EN
  logic pause_q;
  always_ff @(posedge FrameClk) begin
    if (Reset) pause_q <= 1'b1;
    else       pause_q <= Pause;
  end
  assign pause_p = Pause & ~pause_q;
`else
  logic pause_unused;
  assign pause_unused = Pause;
  assign pause_p      = 1'b0;
`endif

  always_ff @(posedge FrameClk) begin
    if (Reset) begin
      state  <= S_MENU;
      timer  <= '0;
      round  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_MENU: begin
          if (cont_p) begin
            state <= S_COUNTDOWN;
            timer <= '0;
            round <= RW'(1);
          end
        end
        S_COUNTDOWN: begin
          if (timer == CD_LAST) begin
            state <= S_PLAY;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_PLAY: begin
          // Expiry is checked first so a pause on the last frame is dropped.
          if (timer == PLAY_LAST) begin
            state  <= (round < LAST_ROUND) ? S_INTER : S_END;
            timer  <= '0;
            done_q <= 1'b1;
          end else if (pause_p) begin
            state <= S_PAUSED;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef ROUND_CTRL_PAUSE_EN
        S_PAUSED: begin
          // The paused-on frame already counted as play, so resume one step on.
          if (pause_p) begin
            state <= S_PLAY;
            timer <= timer + 1'b1;
          end
        end
`endif
        S_INTER: begin
          if (cont_p) begin
            state <= S_COUNTDOWN;
            timer <= '0;
            round <= round + 1'b1;
          end
        end
        S_END: begin
          if (cont_p) begin
            state <= S_MENU;
            timer <= '0;
            round <= '0;
          end
        end
        default: begin
          state <= S_MENU;
          timer <= '0;
          round <= '0;
        end
      endcase
    end
  end

  logic [PW-1:0]    bar_prod;
  logic [PW-1:0]    bar_idx;
  logic [LED_W-1:0] bar;

  // Progress bar empties from the low end as the round timer advances.
  assign bar_prod = PW'(LED_W) * PW'(timer);
  assign bar_idx  = bar_prod / PW'(ROUND_FRAMES);
  assign bar      = LED_ONES << bar_idx;

  always_comb begin
    LED = LED_ONES;
    case (state)
      S_PLAY, S_PAUSED: LED = bar;
      S_INTER, S_END:   LED = '0;
      default:          LED = LED_ONES;
    endcase
  end

  assign State       = state;
  assign RoundNum    = round;
  assign SpawnEnable = (state == S_PLAY);
  assign RoundDone   = done_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Frame-by-frame vector bench for round_ctrl; the pause sequence is built only
// when ROUND_CTRL_PAUSE_EN is defined, otherwise Pause is toggled randomly.
module tb_round_ctrl;

  localparam int RF = 20;
  localparam int NR = 2;
  localparam int CD = 4;
  localparam int LW = 10;
  localparam int TW = 16;
  localparam int RW = $clog2(NR + 1);
  localparam int W  = 3 + RW + 1 + 1 + LW;

  logic          FrameClk = 1'b0;
  logic          Reset    = 1'b1;
  logic          Continue = 1'b0;
  logic          Pause    = 1'b0;
  logic          SpawnEnable;
  logic [RW-1:0] RoundNum;
  logic [2:0]    State;
  logic          RoundDone;
  logic [LW-1:0] LED;

  round_ctrl #(
    .ROUND_FRAMES(RF), .NUM_ROUNDS(NR), .COUNTDOWN_FRAMES(CD),
    .LED_W(LW), .TIMER_W(TW)
  ) dut (
    .FrameClk(FrameClk), .Reset(Reset), .Continue(Continue), .Pause(Pause),
    .SpawnEnable(SpawnEnable), .RoundNum(RoundNum), .State(State),
    .RoundDone(RoundDone), .LED(LED)
  );

  // clock / watchdog
  always #5 FrameClk = ~FrameClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            rst;
    bit            cont;
    bit            pause;
    int            n;
    logic [2:0]    st;
    logic [RW-1:0] rnd;
    bit            done;
  } row_t;

  row_t          rows[$];
  logic [W-1:0]  exp_q[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  int            play_t       = 0;
  int            spawn_cnt    = 0;

  function automatic logic [LW-1:0] led_exp(input int t);
    logic [LW-1:0] ones;
    ones = '1;
    return ones << ((LW * t) / RF);
  endfunction

  task automatic add(input bit rst, input bit cont, input bit pause, input int n,
                     input logic [2:0] st, input logic [RW-1:0] rnd, input bit done);
    row_t r;
    r.rst = rst; r.cont = cont; r.pause = pause; r.n = n;
    r.st = st; r.rnd = rnd; r.done = done;
    rows.push_back(r);
  endtask

  // driver: one frame of stimulus plus its expected outputs after the edge
  task automatic drive_frame(input row_t r, input int idx, input int k);
    logic [LW-1:0] led;
    logic [W-1:0]  e;
    logic [W-1:0]  got;
    @(negedge FrameClk);
    Reset    = r.rst;
    Continue = r.cont;
`ifdef ROUND_CTRL_PAUSE_EN
    Pause = r.pause;
`else
    Pause = 1'($urandom_range(0, 1));
`endif
    if (r.rst || r.st == 3'd1) play_t = 0;
    case (r.st)
      3'd0, 3'd1: led = '1;
      3'd2: begin led = led_exp(play_t); play_t++; end
      3'd3: led = led_exp(play_t - 1);
      default: led = '0;
    endcase
    exp_q.push_back({r.st, r.rnd, (r.st == 3'd2), r.done, led});

    @(posedge FrameClk);
    #1;
    e   = exp_q.pop_front();
    got = {State, RoundNum, SpawnEnable, RoundDone, LED};
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL outputs row%0d frame%0d: got state=%0d round=%0d spawn=%0b done=%0b led=%h, required state=%0d round=%0d spawn=%0b done=%0b led=%h",
               idx, k, State, RoundNum, SpawnEnable, RoundDone, LED,
               e[W-1 -: 3], e[W-4 -: RW], e[LW+1], e[LW], e[LW-1:0]);
    end

    if (r.rst || r.st == 3'd1) spawn_cnt = 0;
    else if (SpawnEnable) spawn_cnt++;
    if (r.done) begin
      tests_run++;
      if (spawn_cnt != RF) begin
        tests_failed++;
        $display("FAIL spawn_frames row%0d: got %0d play frames, required %0d", idx, spawn_cnt, RF);
      end
    end
  endtask

  initial begin
    // full game, two rounds, both buttons together in END
    add(1, 0, 0, 2,  3'd0, 0, 0);
    add(0, 0, 0, 2,  3'd0, 0, 0);
    add(0, 1, 0, 1,  3'd1, 1, 0);
    add(0, 0, 0, 3,  3'd1, 1, 0);
    add(0, 0, 0, 20, 3'd2, 1, 0);
    add(0, 0, 0, 1,  3'd4, 1, 1);
    add(0, 0, 0, 2,  3'd4, 1, 0);
    add(0, 1, 0, 1,  3'd1, 2, 0);
    add(0, 0, 0, 3,  3'd1, 2, 0);
    add(0, 0, 0, 20, 3'd2, 2, 0);
    add(0, 0, 0, 1,  3'd5, 2, 1);
    add(0, 0, 0, 1,  3'd5, 2, 0);
    add(0, 1, 1, 1,  3'd0, 0, 0);
    add(0, 0, 0, 1,  3'd0, 0, 0);
    // Continue held through reset, then a real press, then reset mid-play
    add(1, 1, 0, 2,  3'd0, 0, 0);
    add(0, 1, 0, 10, 3'd0, 0, 0);
    add(0, 0, 0, 1,  3'd0, 0, 0);
    add(0, 1, 0, 1,  3'd1, 1, 0);
    add(0, 0, 0, 3,  3'd1, 1, 0);
    add(0, 0, 0, 5,  3'd2, 1, 0);
    add(1, 0, 0, 1,  3'd0, 0, 0);
    add(0, 0, 0, 1,  3'd0, 0, 0);
`ifdef ROUND_CTRL_PAUSE_EN
    // pause at timer 7 for 5 frames, pause at expiry, buttons ignored where required
    add(0, 1, 0, 1,  3'd1, 1, 0);
    add(0, 0, 0, 3,  3'd1, 1, 0);
    add(0, 0, 0, 8,  3'd2, 1, 0);
    add(0, 0, 1, 1,  3'd3, 1, 0);
    add(0, 1, 0, 2,  3'd3, 1, 0);
    add(0, 0, 0, 2,  3'd3, 1, 0);
    add(0, 0, 1, 1,  3'd2, 1, 0);
    add(0, 0, 0, 11, 3'd2, 1, 0);
    add(0, 0, 1, 1,  3'd4, 1, 1);
    add(0, 0, 0, 1,  3'd4, 1, 0);
    add(0, 0, 1, 1,  3'd4, 1, 0);
    add(0, 1, 1, 1,  3'd1, 2, 0);
    add(0, 0, 0, 1,  3'd1, 2, 0);
    add(0, 0, 1, 2,  3'd1, 2, 0);
    add(0, 0, 0, 20, 3'd2, 2, 0);
    add(0, 0, 0, 1,  3'd5, 2, 1);
`else
    // random Pause activity must leave the round untouched
    add(0, 1, 0, 1,  3'd1, 1, 0);
    add(0, 0, 0, 3,  3'd1, 1, 0);
    add(0, 0, 0, 20, 3'd2, 1, 0);
    add(0, 0, 0, 1,  3'd4, 1, 1);
    add(0, 0, 0, 2,  3'd4, 1, 0);
`endif

    for (int i = 0; i < rows.size(); i++) begin
      for (int k = 0; k < rows[i].n; k++) begin
        drive_frame(rows[i], i, k);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Multi-round game-flow controller for Crossy Robbers, clocked once per video frame. It sequences menu, pre-round countdown, timed play, optional pause, inter-round intermission and game end across a parametrised number of rounds. It gates obstacle/robber spawning and drives a parametrised-width LED progress bar for the remaining round time. It sits between the board push-buttons and the spawner/renderer blocks.

## Interface
- ROUND_FRAMES, 7142, play frames per round (59.52 frames/s × 120 s); must be ≥ 2
- NUM_ROUNDS, 3, rounds per game; ≥ 1
- COUNTDOWN_FRAMES, 180, frames of pre-round countdown; ≥ 1
- LED_W, 10, progress-bar width
- TIMER_W, 16, timer width; 2^TIMER_W > max(ROUND_FRAMES, COUNTDOWN_FRAMES)

Ports:
- FrameClk  in  1  frame clock
- Reset  in  1  synchronous, active-high
- Continue  in  1  level button input; the block acts on its rising edge
- Pause  in  1  level button input; the block acts on its rising edge
- SpawnEnable  out  1  high only in PLAY
- RoundNum  out  $clog2(NUM_ROUNDS+1)  current round, 1-based; 0 in MENU
- State  out  3  encoding: MENU=0, COUNTDOWN=1, PLAY=2, PAUSED=3, INTERMISSION=4, END=5
- RoundDone  out  1  one-frame pulse on the frame the FSM enters INTERMISSION or END from PLAY
- LED  out  LED_W  remaining-time bar

## Operation
- Edge detect: cont_q <= Continue; pause_q <= Pause. cont_p = Continue & ~cont_q; pause_p likewise.
- Reset sets cont_q and pause_q to 1, so a button held through reset produces no edge.
- One timer (TIMER_W bits) serves both COUNTDOWN and PLAY. It clears on every state entry.
- MENU: cont_p -> COUNTDOWN, round <= 1.
- COUNTDOWN: timer counts. At timer == COUNTDOWN_FRAMES-1 -> PLAY. Pause and Continue are ignored.
- PLAY: timer counts. At timer == ROUND_FRAMES-1 -> INTERMISSION if round < NUM_ROUNDS, else END; RoundDone = 1. A pause_p in PLAY -> PAUSED.
- PAUSED: timer holds its value (it does not clear). pause_p -> PLAY, and counting resumes from the held value. Continue is ignored.
- INTERMISSION: cont_p -> COUNTDOWN, round <= round+1.
- END: cont_p -> MENU, round <= 0.
- The FSM is Moore: all outputs decode registered state, timer and round.
- LED in PLAY/PAUSED: {LED_W{1}} << floor(LED_W*timer/ROUND_FRAMES).
  - The product is computed at TIMER_W+$clog2(LED_W)+1 bits with no truncation.
- LED in MENU/COUNTDOWN: all ones. LED in INTERMISSION/END: all zeros.

## Timing
- Reset values: State=MENU, timer=0, round=0, SpawnEnable=0, RoundNum=0, RoundDone=0, LED=all ones.
- Reset mid-game returns to MENU on the next edge, whatever the state.
- Button-to-state latency: a Continue rising edge sampled high at edge k gives the new State after edge k (same frame). The press must be low for at least one frame between edges.
- A PLAY round lasts exactly ROUND_FRAMES frames of SpawnEnable=1, excluding paused frames. COUNTDOWN lasts exactly COUNTDOWN_FRAMES frames.
- If pause_p and expiry (timer == ROUND_FRAMES-1) occur in the same frame, expiry wins: no PAUSED entry.
- If both buttons are pressed together in INTERMISSION/END, only Continue acts.
- The timer never wraps; it saturates at its terminal compare.

## Configuration
- ROUND_CTRL_PAUSE_EN defined: the PAUSED state and Pause handling are as above.
- Not defined:
  - The Pause port is present but ignored.
  - pause_q is not instantiated.
  - PAUSED is unreachable; encoding 3 is never output.
  - An illegal state recovers to MENU in both builds.

## Test plan
Bench parameters: ROUND_FRAMES=20, NUM_ROUNDS=2, COUNTDOWN_FRAMES=4, LED_W=10.
- Reset, then a Continue pulse -> State=1 for exactly 4 frames, then State=2, SpawnEnable=1, LED=10'h3FF, RoundNum=1.
- Play through round 1 -> at timer=19, LED=10'b1000000000. Next frame State=4, RoundDone=1 for one frame, LED=0, SpawnEnable low after exactly 20 high frames.
- Continue in INTERMISSION, then complete round 2 -> State=5, RoundNum=2. Continue -> State=0, RoundNum=0.
- Hold Continue high through reset and for 10 frames -> State stays 0. Release, then press -> State=1.
- PAUSE_EN: Pause edge at play timer=7 -> State=3 and the timer holds 7 for 5 frames. Pause edge -> PLAY, and the round ends after 20 play frames in total. Pause edge at timer=19 -> State=4, never 3.
- Without PAUSE_EN: toggle Pause throughout -> identical trace to a run with Pause tied to 0.
